// File: rtl/axil_lite_master_if.sv
// axil_lite_master_if: bundles the command/response port and the AXI4-Lite
// master-side channels of axil_lite_master.
//   master modport : initiator view (cmd in, rsp out, AXI master side)
//   slave modport  : controller + AXI slave view (drives cmd, rsp_ready, slave returns)
// Parameter: ADDR_WIDTH (cmd_addr/awaddr/araddr width). Data is fixed at 32 bits.
interface axil_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  // Command port
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_wstrb;
  // Response port
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;
  // AXI4-Lite write channels
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  // AXI4-Lite read channels
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready
  );
endinterface

// File: rtl/axil_lite_master.sv
// axil_lite_master: single-outstanding AXI4-Lite initiator. Converts a
// valid/ready command into one AXI4-Lite write or read and returns the
// read data and response code on a registered response port.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : axil_lite_master_if.master (cmd, rsp, AW/W/B, AR/R channels)
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to enable the response-phase
// watchdog (TIMEOUT_CYCLES cycles in WR_RESP/RD_DATA -> rsp_resp=2'b10,
// rsp_timeout=1); bready/rready are then also high in IDLE to drop late beats.
module axil_lite_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               rst,
  axil_lite_master_if.master bus
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // Elaboration guard on the fixed data width and the watchdog minimum
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axil_lite_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_e;

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    expired_c;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero on the first cycle in a wait state, so the last wait
  // cycle is TIMEOUT_CYCLES-1 and RSP follows TIMEOUT_CYCLES cycles after entry.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == WR_RESP || state_q == RD_DATA)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_c  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.bready = (state_q == WR_RESP) || (state_q == IDLE);
  assign bus.rready = (state_q == RD_DATA) || (state_q == IDLE);
`else
  assign expired_c  = 1'b0;
  assign bus.bready = (state_q == WR_RESP);
  assign bus.rready = (state_q == RD_DATA);
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          if (bus.cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        // A low valid means that channel's handshake already completed
        if (bus.awready) awvalid_d = 1'b0;
        if (bus.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bus.bvalid) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = bus.bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (expired_c) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end
      RD_ADDR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.rvalid) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = bus.rdata;
          rsp_resp_d    = bus.rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (expired_c) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.awvalid     = awvalid_q;
  assign bus.awaddr      = addr_q;
  assign bus.wvalid      = wvalid_q;
  assign bus.wdata       = wdata_q;
  assign bus.wstrb       = wstrb_q;
  assign bus.arvalid     = arvalid_q;
  assign bus.araddr      = addr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_resp    = rsp_resp_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
